// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite constants and a byte-strobe merge helper used by the
// AXI4-Lite slaves in this block.
package axi4_lite_pkg;

    localparam int AXIL_DATA_WIDTH = 32;
    localparam int AXIL_STRB_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Merge new data into the old word, one byte lane per strobe bit.
    function automatic logic [AXIL_DATA_WIDTH-1:0] apply_strb(
        input logic [AXIL_DATA_WIDTH-1:0] cur,
        input logic [AXIL_DATA_WIDTH-1:0] nxt,
        input logic [AXIL_STRB_WIDTH-1:0] strb
    );
        logic [AXIL_DATA_WIDTH-1:0] res;
        res = cur;
        for (int k = 0; k < AXIL_STRB_WIDTH; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = nxt[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_write_join.sv
// Joins the independent AW and W channels of an AXI4-Lite slave into a single
// write command. Each channel has a one-entry hold; the command is offered
// once both holds are full and retires on cmd_valid && cmd_ready.
module axi4_lite_write_join
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      awaddr,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [AXIL_DATA_WIDTH-1:0] wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [ADDR_WIDTH-1:0]      cmd_addr,
    output logic [AXIL_DATA_WIDTH-1:0] cmd_data,
    output logic [AXIL_STRB_WIDTH-1:0] cmd_strb,
    output logic                       cmd_valid,
    input  logic                       cmd_ready
);

    logic alive;
    logic aw_full;
    logic w_full;

    // Readies stay low through reset and come up one edge after release.
    assign awready   = alive && !aw_full;
    assign wready    = alive && !w_full;
    assign cmd_valid = aw_full && w_full;

    // Hold registers: a handshake fills a hold, a command retirement empties both.
    // A full hold drops its ready, so fill and retire never hit the same hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive    <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            cmd_addr <= '0;
            cmd_data <= '0;
            cmd_strb <= '0;
        end else begin
            alive <= 1'b1;
            if (cmd_valid && cmd_ready) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
            if (awvalid && awready) begin
                aw_full  <= 1'b1;
                cmd_addr <= awaddr;
            end
            if (wvalid && wready) begin
                w_full   <= 1'b1;
                cmd_data <= wdata;
                cmd_strb <= wstrb;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_regbank.sv
// Parametrised AXI4-Lite register bank: NUM_REGS 32-bit registers, each either
// bus-writable or a read-only view of reg_in. Unmapped and read-only writes
// answer SLVERR. Read and write paths are independent.
module axi4_lite_regbank
    import axi4_lite_pkg::*;
#(
    parameter int                       NUM_REGS    = 4,
    parameter int                       ADDR_WIDTH  = 4,
    parameter logic [NUM_REGS-1:0]      RO_MASK     = '0,
    parameter logic [NUM_REGS*32-1:0]   RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic [2:0]               arprot,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [NUM_REGS*32-1:0]   reg_out,
    input  logic [NUM_REGS*32-1:0]   reg_in,
    output logic [NUM_REGS-1:0]      wr_pulse,
    output logic [NUM_REGS-1:0]      rd_pulse
);

    logic [31:0]           regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_data;
    logic [3:0]            cmd_strb;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  commit;
    logic [31:0]           w_idx;
    logic [31:0]           r_idx;
    logic [NUM_REGS-1:0]   wr_hit;
    logic [NUM_REGS-1:0]   rd_hit;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [31:0]           rd_word;
    logic                  rd_alive;
    logic                  unused_ok;

    // Protection bits and the byte offset within a word carry no meaning here.
    assign unused_ok = ^{awprot, arprot, cmd_addr[1:0], araddr[1:0]};

    axi4_lite_write_join #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_write_join (
        .clk       (clk),
        .rst       (rst),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_strb  (cmd_strb),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready)
    );

    // A commit needs a free B slot: either empty or draining this edge.
    assign cmd_ready = !bvalid || bready;
    assign commit    = cmd_valid && cmd_ready;
    assign w_idx     = 32'(cmd_addr[ADDR_WIDTH-1:2]);
    assign r_idx     = 32'(araddr[ADDR_WIDTH-1:2]);
    assign arready   = rd_alive && (!rvalid || rready);

    // Address decode for both paths; an index with no hit is out of range.
    always_comb begin
        wr_hit  = '0;
        rd_hit  = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == i && !RO_MASK[i]) begin
                wr_hit[i] = 1'b1;
            end
            if (r_idx == i) begin
                rd_hit[i] = 1'b1;
                rd_word   = RO_MASK[i] ? reg_in[32*i +: 32] : regs[i];
            end
        end
        wr_ok = |wr_hit;
        rd_ok = |rd_hit;
    end

    // Export RW register values; read-only slots present zero.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!RO_MASK[i]) begin
                reg_out[32*i +: 32] = regs[i];
            end
        end
    end

    // Register array: strobed byte update on an OKAY commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE[32*i +: 32];
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= apply_strb(regs[i], cmd_data, cmd_strb);
                end
            end
        end
    end

    // Write response and write pulse; a commit while draining reloads bvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    wr_pulse <= wr_hit;
                end
            end else if (bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read response: data captured at the AR handshake, pulse on the first rvalid cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_alive <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rd_pulse <= '0;
        end else begin
            rd_alive <= 1'b1;
            rd_pulse <= '0;
            if (arvalid && arready) begin
                rvalid   <= 1'b1;
                rdata    <= rd_ok ? rd_word : 32'h0;
                rresp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                rd_pulse <= rd_hit;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Bench for axi4_lite_regbank. Two instances share every input: bank A has four
// registers with slot 3 read-only, bank B has three registers so 0xC is unmapped.
module tb_axi4_lite_regbank;
    import axi4_lite_pkg::*;

    localparam logic [127:0] RESET_A   = {32'h33333333, 32'h22222222, 32'h01010101, 32'hAAAAAAAA};
    localparam logic [95:0]  RESET_B   = {32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
    localparam logic [127:0] REGOUT_A0 = {32'h00000000, 32'h22222222, 32'h01010101, 32'hAAAAAAAA};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b0;
    logic [127:0] reg_in_a = '0;
    logic [95:0]  reg_in_b = '0;

    logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
    logic [1:0]  bresp_a, rresp_a;
    logic [31:0] rdata_a;
    logic [127:0] reg_out_a;
    logic [3:0]  wr_pulse_a, rd_pulse_a;

    logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
    logic [1:0]  bresp_b, rresp_b;
    logic [31:0] rdata_b;
    logic [95:0] reg_out_b;
    logic [2:0]  wr_pulse_b, rd_pulse_b;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    always #5 clk = ~clk;

    axi4_lite_regbank #(
        .NUM_REGS (4), .ADDR_WIDTH (4), .RO_MASK (4'b1000), .RESET_VALUE (RESET_A)
    ) dut_a (
        .clk (clk), .rst (rst),
        .awaddr (awaddr), .awprot (awprot), .awvalid (awvalid), .awready (awready_a),
        .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid), .wready (wready_a),
        .bresp (bresp_a), .bvalid (bvalid_a), .bready (bready),
        .araddr (araddr), .arprot (arprot), .arvalid (arvalid), .arready (arready_a),
        .rdata (rdata_a), .rresp (rresp_a), .rvalid (rvalid_a), .rready (rready),
        .reg_out (reg_out_a), .reg_in (reg_in_a),
        .wr_pulse (wr_pulse_a), .rd_pulse (rd_pulse_a)
    );

    axi4_lite_regbank #(
        .NUM_REGS (3), .ADDR_WIDTH (4), .RO_MASK (3'b000), .RESET_VALUE (RESET_B)
    ) dut_b (
        .clk (clk), .rst (rst),
        .awaddr (awaddr), .awprot (awprot), .awvalid (awvalid), .awready (awready_b),
        .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid), .wready (wready_b),
        .bresp (bresp_b), .bvalid (bvalid_b), .bready (bready),
        .araddr (araddr), .arprot (arprot), .arvalid (arvalid), .arready (arready_b),
        .rdata (rdata_b), .rresp (rresp_b), .rvalid (rvalid_b), .rready (rready),
        .reg_out (reg_out_b), .reg_in (reg_in_b),
        .wr_pulse (wr_pulse_b), .rd_pulse (rd_pulse_b)
    );

    // Drivers: assert valid on a falling edge, hold until a rising edge sees ready.
    task automatic send_aw(input logic [3:0] addr);
        int n = 0;
        awaddr = addr;
        awvalid = 1'b1;
        while (!awready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!awready_a) begin
            vectors++; miscompares++;
            $display("FAIL aw_timeout: awready=%b after %0d cycles, want 1", awready_a, n);
        end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        wdata = data;
        wstrb = strb;
        wvalid = 1'b1;
        while (!wready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wready_a) begin
            vectors++; miscompares++;
            $display("FAIL w_timeout: wready=%b after %0d cycles, want 1", wready_a, n);
        end
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] addr);
        int n = 0;
        araddr = addr;
        arvalid = 1'b1;
        while (!arready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!arready_a) begin
            vectors++; miscompares++;
            $display("FAIL ar_timeout: arready=%b after %0d cycles, want 1", arready_a, n);
        end
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        while (!bvalid_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid_a) begin
            vectors++; miscompares++;
            $display("FAIL b_timeout: bvalid=%b after %0d cycles, want 1", bvalid_a, n);
        end
    endtask

    task automatic wait_r();
        int n = 0;
        while (!rvalid_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid_a) begin
            vectors++; miscompares++;
            $display("FAIL r_timeout: rvalid=%b after %0d cycles, want 1", rvalid_a, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({awready_a, wready_a, arready_a, bvalid_a, rvalid_a} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_handshake: aw/w/ar ready, bvalid, rvalid = %b, want 00000",
                     {awready_a, wready_a, arready_a, bvalid_a, rvalid_a});
        end
        vectors++;
        if ({bresp_a, rresp_a, rdata_a, wr_pulse_a, rd_pulse_a} !== 44'h0) begin
            miscompares++;
            $display("FAIL rst_outputs: bresp=%b rresp=%b rdata=%h wr=%b rd=%b, want all 0",
                     bresp_a, rresp_a, rdata_a, wr_pulse_a, rd_pulse_a);
        end
        vectors++;
        if (reg_out_a !== REGOUT_A0) begin
            miscompares++;
            $display("FAIL rst_regs_a: reg_out=%h, want %h", reg_out_a, REGOUT_A0);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({awready_a, wready_a, arready_a} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_release_early: readies=%b, want 000", {awready_a, wready_a, arready_a});
        end
        @(negedge clk);
        vectors++;
        if ({awready_a, wready_a, arready_a, awready_b} !== 4'b1111) begin
            miscompares++;
            $display("FAIL rst_release: readies=%b, want 1111",
                     {awready_a, wready_a, arready_a, awready_b});
        end
        vectors++;
        if (reg_out_b !== RESET_B) begin
            miscompares++;
            $display("FAIL rst_regs_b: reg_out=%h, want %h", reg_out_b, RESET_B);
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0]  eb;
        logic [33:0] er;
        bready = 1'b1;
        rready = 1'b1;
        bq.push_back(RESP_OKAY);
        fork
            send_aw(4'h4);
            send_w(32'hDEADBEEF, 4'hF);
        join
        wait_b();
        eb = bq.pop_front();
        vectors++;
        if (bresp_a !== eb) begin
            miscompares++;
            $display("FAIL same_bresp: got %b, want %b", bresp_a, eb);
        end
        vectors++;
        if (wr_pulse_a !== 4'b0010) begin
            miscompares++;
            $display("FAIL same_wr_pulse: got %b, want 0010", wr_pulse_a);
        end
        @(negedge clk);
        vectors++;
        if ({bvalid_a, wr_pulse_a} !== 5'b0) begin
            miscompares++;
            $display("FAIL same_pulse_width: bvalid=%b wr_pulse=%b, want 0 0000", bvalid_a, wr_pulse_a);
        end
        vectors++;
        if (reg_out_a[63:32] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL same_reg: got %h, want deadbeef", reg_out_a[63:32]);
        end
        rq.push_back({RESP_OKAY, 32'hDEADBEEF});
        send_ar(4'h4);
        wait_r();
        er = rq.pop_front();
        vectors++;
        if ({rresp_a, rdata_a} !== er) begin
            miscompares++;
            $display("FAIL same_read: rresp=%b rdata=%h, want %b %h", rresp_a, rdata_a, er[33:32], er[31:0]);
        end
        vectors++;
        if (rd_pulse_a !== 4'b0010) begin
            miscompares++;
            $display("FAIL same_rd_pulse: got %b, want 0010", rd_pulse_a);
        end
        @(negedge clk);
    endtask

    task automatic test_w_before_aw();
        logic [1:0] eb;
        int cyc;
        bq.push_back(RESP_OKAY);
        send_w(32'h11223344, 4'b0101);
        repeat (2) @(negedge clk);
        vectors++;
        if (bvalid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL wfirst_early_b: bvalid=%b with only W held, want 0", bvalid_a);
        end
        awaddr = 4'h0;
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        cyc = 1;
        while (!bvalid_a && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc != 2) begin
            miscompares++;
            $display("FAIL wfirst_latency: bvalid after %0d cycles, want 2", cyc);
        end
        eb = bq.pop_front();
        vectors++;
        if (bresp_a !== eb) begin
            miscompares++;
            $display("FAIL wfirst_bresp: got %b, want %b", bresp_a, eb);
        end
        vectors++;
        if (reg_out_a[31:0] !== 32'hAA22AA44) begin
            miscompares++;
            $display("FAIL wfirst_strobe: reg0=%h, want aa22aa44", reg_out_a[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_read_only();
        logic [1:0]  eb;
        logic [33:0] er;
        reg_in_a[127:96] = 32'h12345678;
        bq.push_back(RESP_SLVERR);
        fork
            send_aw(4'hC);
            send_w(32'hFFFFFFFF, 4'hF);
        join
        wait_b();
        eb = bq.pop_front();
        vectors++;
        if ({bresp_a, wr_pulse_a} !== {eb, 4'b0000}) begin
            miscompares++;
            $display("FAIL ro_write: bresp=%b wr_pulse=%b, want %b 0000", bresp_a, wr_pulse_a, eb);
        end
        vectors++;
        if (reg_out_a[127:96] !== 32'h0) begin
            miscompares++;
            $display("FAIL ro_reg_out: slot3=%h, want 00000000", reg_out_a[127:96]);
        end
        @(negedge clk);
        rq.push_back({RESP_OKAY, 32'h12345678});
        send_ar(4'hC);
        wait_r();
        er = rq.pop_front();
        vectors++;
        if ({rresp_a, rdata_a} !== er) begin
            miscompares++;
            $display("FAIL ro_read: rresp=%b rdata=%h, want %b %h", rresp_a, rdata_a, er[33:32], er[31:0]);
        end
        vectors++;
        if (rd_pulse_a !== 4'b1000) begin
            miscompares++;
            $display("FAIL ro_rd_pulse: got %b, want 1000", rd_pulse_a);
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        logic [1:0]  eb;
        logic [33:0] er;
        bq.push_back(RESP_SLVERR);
        fork
            send_aw(4'hC);
            send_w(32'h55555555, 4'hF);
        join
        wait_b();
        eb = bq.pop_front();
        vectors++;
        if ({bresp_b, wr_pulse_b} !== {eb, 3'b000}) begin
            miscompares++;
            $display("FAIL oor_write: bresp=%b wr_pulse=%b, want %b 000", bresp_b, wr_pulse_b, eb);
        end
        vectors++;
        if (reg_out_b !== {32'h0C0C0C0C, 32'hDEADBEEF, 32'h0A220A44}) begin
            miscompares++;
            $display("FAIL oor_regs: reg_out=%h, want 0c0c0c0cdeadbeef0a220a44", reg_out_b);
        end
        @(negedge clk);
        rq.push_back({RESP_SLVERR, 32'h0});
        send_ar(4'hC);
        wait_r();
        er = rq.pop_front();
        vectors++;
        if ({rresp_b, rdata_b, rd_pulse_b} !== {er, 3'b000}) begin
            miscompares++;
            $display("FAIL oor_read: rresp=%b rdata=%h rd_pulse=%b, want %b %h 000",
                     rresp_b, rdata_b, rd_pulse_b, er[33:32], er[31:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic [1:0]  eb;
        logic [33:0] er;
        int rv_cnt = 0;
        bready = 1'b0;
        bq.push_back(RESP_OKAY);
        bq.push_back(RESP_OKAY);
        fork
            send_aw(4'h0);
            send_w(32'h00000001, 4'hF);
        join
        fork
            send_aw(4'h4);
            send_w(32'h00000002, 4'hF);
        join
        repeat (5) @(negedge clk);
        eb = bq.pop_front();
        vectors++;
        if ({bvalid_a, bresp_a} !== {1'b1, eb}) begin
            miscompares++;
            $display("FAIL bp_first_b: bvalid=%b bresp=%b, want 1 %b", bvalid_a, bresp_a, eb);
        end
        vectors++;
        if ({awready_a, wready_a, reg_out_a[63:32]} !== {2'b00, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL bp_stalled: awready=%b wready=%b reg1=%h, want 0 0 deadbeef",
                     awready_a, wready_a, reg_out_a[63:32]);
        end
        bready = 1'b1;
        @(negedge clk);
        eb = bq.pop_front();
        vectors++;
        if ({bvalid_a, bresp_a, wr_pulse_a} !== {1'b1, eb, 4'b0010}) begin
            miscompares++;
            $display("FAIL bp_second_b: bvalid=%b bresp=%b wr_pulse=%b, want 1 %b 0010",
                     bvalid_a, bresp_a, wr_pulse_a, eb);
        end
        vectors++;
        if (reg_out_a[63:0] !== {32'h00000002, 32'h00000001}) begin
            miscompares++;
            $display("FAIL bp_regs: reg1/reg0=%h, want 0000000200000001", reg_out_a[63:0]);
        end
        @(negedge clk);
        rready = 1'b1;
        rq.push_back({RESP_OKAY, 32'h00000001});
        rq.push_back({RESP_OKAY, 32'h00000002});
        rq.push_back({RESP_OKAY, 32'h22222222});
        rq.push_back({RESP_OKAY, 32'h12345678});
        araddr = 4'h0;
        arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rvalid_a) rv_cnt++;
            er = rq.pop_front();
            vectors++;
            if ({rresp_a, rdata_a} !== er) begin
                miscompares++;
                $display("FAIL b2b_read%0d: rresp=%b rdata=%h, want %b %h",
                         i, rresp_a, rdata_a, er[33:32], er[31:0]);
            end
            if (i < 3) araddr = 4'((i + 1) * 4);
            else arvalid = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (rv_cnt != 4 || rvalid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count: rvalid cycles=%0d then rvalid=%b, want 4 then 0", rv_cnt, rvalid_a);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_b = 1'b0;
        bready = 1'b1;
        send_aw(4'h0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_w(32'h99999999, 4'hF);
        repeat (6) begin
            seen_b = seen_b | bvalid_a;
            @(negedge clk);
        end
        vectors++;
        if (seen_b !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_b: bvalid seen=%b, want 0", seen_b);
        end
        vectors++;
        if (reg_out_a !== REGOUT_A0 || reg_out_b !== RESET_B) begin
            miscompares++;
            $display("FAIL mid_reset_regs: a=%h b=%h, want %h %h", reg_out_a, reg_out_b, REGOUT_A0, RESET_B);
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_read_only();
        test_out_of_range();
        test_back_pressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
